// File: rtl/stopwatch_pkg.sv
// Shared types, glyph constants and BCD helpers for the minutes:seconds stopwatch.
package stopwatch_pkg;

    localparam int unsigned SEG_W = 8;
    localparam int unsigned AN_W  = 4;

    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        FLD_MIN = 1'b0,
        FLD_SEC = 1'b1
    } field_sel_e;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
    } sw_time_t;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    function automatic logic [6:0] glyph(input bcd_t d);
        logic [6:0] g;
        g = GLYPH_BLANK;
        case (d)
            4'd0: g = GLYPH_0;
            4'd1: g = GLYPH_1;
            4'd2: g = GLYPH_2;
            4'd3: g = GLYPH_3;
            4'd4: g = GLYPH_4;
            4'd5: g = GLYPH_5;
            4'd6: g = GLYPH_6;
            4'd7: g = GLYPH_7;
            4'd8: g = GLYPH_8;
            4'd9: g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Two-digit BCD increment modulo 60
    function automatic logic [7:0] bcd60_inc(input bcd_t tens, input bcd_t ones);
        logic [7:0] r;
        if (ones != 4'd9)      r = {tens, ones + 4'd1};
        else if (tens != 4'd5) r = {tens + 4'd1, 4'd0};
        else                   r = 8'h00;
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_mux.sv
// Scans four BCD digits onto a multiplexed active-low 7-segment display,
// with field blanking and the dp on digit 2 as a colon.
module seven_seg_mux
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  sw_time_t         disp,
    input  field_sel_e       sel,
    input  logic             blank_sel,
    output logic [SEG_W-1:0] seg,
    output logic [AN_W-1:0]  an
);

    logic [1:0]       idx;
    bcd_t             digit_c;
    field_sel_e       field_c;
    logic             blank_c;
    logic [SEG_W-1:0] seg_c;
    logic [AN_W-1:0]  an_c;

    always_comb begin
        digit_c = disp.sec_o;
        field_c = FLD_SEC;
        case (idx)
            2'd3: begin digit_c = disp.min_t; field_c = FLD_MIN; end
            2'd2: begin digit_c = disp.min_o; field_c = FLD_MIN; end
            2'd1: begin digit_c = disp.sec_t; field_c = FLD_SEC; end
            default: ;
        endcase
        blank_c    = blank_sel && (field_c == sel);
        seg_c[6:0] = blank_c ? GLYPH_BLANK : glyph(digit_c);
        seg_c[7]   = (idx == 2'd2) ? SEG_ON : SEG_OFF;
        an_c       = {AN_W{AN_OFF}};
        an_c[idx]  = AN_ON;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd3;
            seg <= {SEG_OFF, GLYPH_0};
            an  <= {AN_ON, {(AN_W-1){AN_OFF}}};
        end else begin
            if (step) idx <= idx - 2'd1;
            seg <= seg_c;
            an  <= an_c;
        end
    end

endmodule

// File: rtl/stopwatch_unit.sv
// Minutes:seconds stopwatch top: button/switch conditioning, tick dividers,
// BCD time keeping with adjust and hold, feeding the display scanner.
module stopwatch_unit
    import stopwatch_pkg::*;
#(
    parameter int unsigned ONE_HZ_DIV      = 100_000_000,
    parameter int unsigned ADJ_DIV         = 50_000_000,
    parameter int unsigned BLINK_DIV       = 25_000_000,
    parameter int unsigned REFRESH_DIV     = 100_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             btnR,
    input  logic             btnS,
    input  logic [2:0]       sw,
    output logic [SEG_W-1:0] seg,
    output logic [AN_W-1:0]  an
);

    localparam int unsigned HZ_W    = (ONE_HZ_DIV > 1)      ? $clog2(ONE_HZ_DIV)      : 1;
    localparam int unsigned ADJ_W   = (ADJ_DIV > 1)         ? $clog2(ADJ_DIV)         : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1)       ? $clog2(BLINK_DIV)       : 1;
    localparam int unsigned REF_W   = (REFRESH_DIV > 1)     ? $clog2(REFRESH_DIV)     : 1;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]         btn_sync;
    logic [2:0]         sw_meta;
    logic [2:0]         sw_s;
    logic               db_state;
    logic [DB_W-1:0]    db_cnt;
    logic               running;
    logic [HZ_W-1:0]    hz_cnt;
    logic [ADJ_W-1:0]   adj_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [REF_W-1:0]   ref_cnt;
    logic               blink_on;
    logic               hold_active;
    sw_time_t           live;
    sw_time_t           held;

    logic       adj_c, hold_c, db_flip_c, press_c;
    logic       tick_1hz_c, tick_adj_c, blink_tog_c, refresh_c;
    logic       sec_wrap_c, blank_sel_c;
    field_sel_e sel_c;
    logic [7:0] sec_inc_c, min_inc_c;
    sw_time_t   disp_c;

    always_comb begin
        adj_c       = sw_s[0];
        sel_c       = field_sel_e'(sw_s[1]);
        hold_c      = sw_s[2];
        db_flip_c   = (btn_sync[1] != db_state) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        press_c     = db_flip_c && btn_sync[1];
        tick_1hz_c  = running && !adj_c && (hz_cnt == HZ_W'(ONE_HZ_DIV - 1));
        tick_adj_c  = adj_c && (adj_cnt == ADJ_W'(ADJ_DIV - 1));
        blink_tog_c = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
        refresh_c   = (ref_cnt == REF_W'(REFRESH_DIV - 1));
        sec_inc_c   = bcd60_inc(live.sec_t, live.sec_o);
        min_inc_c   = bcd60_inc(live.min_t, live.min_o);
        sec_wrap_c  = (live.sec_t == 4'd5) && (live.sec_o == 4'd9);
        disp_c      = (hold_active && !adj_c) ? held : live;
        blank_sel_c = adj_c && !blink_on;
    end

    // Synchronisers, debounce and start/pause toggle; a tick in the same
    // cycle as a press still sees the old running value.
    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_s     <= '0;
            db_state <= 1'b0;
            db_cnt   <= '0;
            running  <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], btnS};
            sw_meta  <= sw;
            sw_s     <= sw_meta;
            if (btn_sync[1] == db_state) begin
                db_cnt <= '0;
            end else if (db_flip_c) begin
                db_state <= ~db_state;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            running <= running ^ press_c;
        end
    end

    // 1 Hz freezes while paused or adjusting; adjust divider advances only in ADJ
    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            hz_cnt    <= '0;
            adj_cnt   <= '0;
            blink_cnt <= '0;
            ref_cnt   <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (running && !adj_c) hz_cnt <= tick_1hz_c ? '0 : hz_cnt + HZ_W'(1);
            if (adj_c)             adj_cnt <= tick_adj_c ? '0 : adj_cnt + ADJ_W'(1);
            blink_cnt <= blink_tog_c ? '0 : blink_cnt + BLINK_W'(1);
            ref_cnt   <= refresh_c ? '0 : ref_cnt + REF_W'(1);
            if (blink_tog_c) blink_on <= ~blink_on;
        end
    end

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            live        <= '0;
            held        <= '0;
            hold_active <= 1'b0;
        end else begin
            if (adj_c) begin
                if (tick_adj_c) begin
                    if (sel_c == FLD_SEC) {live.sec_t, live.sec_o} <= sec_inc_c;
                    else                  {live.min_t, live.min_o} <= min_inc_c;
                end
            end else if (tick_1hz_c) begin
                {live.sec_t, live.sec_o} <= sec_inc_c;
                if (sec_wrap_c) {live.min_t, live.min_o} <= min_inc_c;
            end
            hold_active <= hold_c;
            if (hold_c && !hold_active) held <= live;
        end
    end

    seven_seg_mux u_mux (
        .clk       (clk),
        .rst_n     (btnR),
        .step      (refresh_c),
        .disp      (disp_c),
        .sel       (sel_c),
        .blank_sel (blank_sel_c),
        .seg       (seg),
        .an        (an)
    );

endmodule

// File: tb/tb_stopwatch_unit.sv
// Randomised scoreboard bench for stopwatch_unit: a seconds-count model predicts
// each displayed frame, and a monitor decodes scanned frames and compares.
module tb_stopwatch_unit;

    localparam int unsigned HZ = 10, ADJ = 5, BLINK = 4, REFRESH = 2, DEB = 3;

    logic       clk  = 1'b0;
    logic       btnR = 1'b0;
    logic       btnS = 1'b0;
    logic [2:0] sw   = 3'b000;
    logic [7:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] word;
        int          cyc;
        int          tag;
    } exp_t;
    exp_t sb_q[$];

    // Model: time as a plain seconds count plus enabled-cycle remainders of each divider
    int t_sec = 0, held_sec = 0, hz_acc = 0, adj_acc = 0, tag_n = 0;
    bit hold_m = 1'b0;

    stopwatch_unit #(
        .ONE_HZ_DIV(HZ), .ADJ_DIV(ADJ), .BLINK_DIV(BLINK),
        .REFRESH_DIV(REFRESH), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .btnR(btnR), .btnS(btnS), .sw(sw), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] glyph8(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] frame_of(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {glyph8(m / 10), glyph8(m % 10) & 8'h7F, glyph8(s / 10), glyph8(s % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    task automatic expect_display();
        exp_t e;
        int   waited;
        e.word = frame_of(hold_m ? held_sec : t_sec);
        e.cyc  = cyc;
        e.tag  = tag_n++;
        sb_q.push_back(e);
        waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin step(1); waited++; end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout tag=%0d got=none expected=%h", e.tag, e.word);
            sb_q.delete();
        end
    endtask

    task automatic press();
        btnS = 1'b1; step(5); btnS = 1'b0;
    endtask

    task automatic run_for(input int r);
        int c0, r_act;
        c0 = cyc;
        press();
        step(r - 5);
        r_act = cyc - c0;
        press();
        step(20);
        hz_acc += r_act;
        t_sec   = (t_sec + hz_acc / HZ) % 3600;
        hz_acc  = hz_acc % HZ;
    endtask

    task automatic apply_adj(input bit fld_sec, input int n);
        int k, m, s;
        k       = (adj_acc + n) / ADJ;
        adj_acc = (adj_acc + n) % ADJ;
        m = t_sec / 60;
        s = t_sec % 60;
        if (fld_sec) s = (s + k) % 60;
        else         m = (m + k) % 60;
        t_sec = m * 60 + s;
    endtask

    task automatic adjust(input bit fld_sec, input int n);
        int c0;
        sw[1] = fld_sec; step(3);
        c0 = cyc; sw[0] = 1'b1; step(n);
        n = cyc - c0; sw[0] = 1'b0; step(6);
        apply_adj(fld_sec, n);
    endtask

    task automatic set_field(input bit fld_sec, input int target);
        int cur, k;
        cur = fld_sec ? (t_sec % 60) : (t_sec / 60);
        k   = (target - cur + 60) % 60;
        if (k > 0) adjust(fld_sec, k * ADJ - adj_acc);
    endtask

    task automatic blink_check();
        int c0, n, sel_blank, other_blank;
        sel_blank = 0; other_blank = 0;
        sw[1] = 1'b1; step(3);
        c0 = cyc; sw[0] = 1'b1; step(4);
        repeat (40) begin
            @(negedge clk);
            if (an == 4'b1101 || an == 4'b1110) begin
                if (seg == 8'hFF) sel_blank++;
            end else if ((seg | 8'h80) == 8'hFF) begin
                other_blank++;
            end
        end
        @(posedge clk); #1;
        n = cyc - c0; sw[0] = 1'b0; step(6);
        apply_adj(1'b1, n);
        checks++;
        if (sel_blank == 0) begin
            errors++;
            $display("FAIL blink_sel_blank got=%0d expected=nonzero", sel_blank);
        end
        check("blink_other_lit", 32'(other_blank), 32'd0);
    endtask

    // Monitor: scan-order check on every digit step, frame compare against scoreboard head
    logic [3:0]  prev_an = 4'b0111;
    logic [3:0]  got     = 4'b0000;
    logic [31:0] fw      = '0;
    int          fstart  = 0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!btnR) begin
            prev_an = 4'b0111;
            got     = 4'b0000;
            fstart  = cyc;
        end else begin
            if (an != prev_an) begin
                checks++;
                if (an != {prev_an[0], prev_an[3:1]}) begin
                    errors++;
                    $display("FAIL scan_order got=%b expected=%b", an, {prev_an[0], prev_an[3:1]});
                end
                if (prev_an == 4'b1110 && got == 4'b1111 && sb_q.size() != 0 && fstart >= sb_q[0].cyc) begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (fw !== mon_e.word) begin
                        errors++;
                        $display("FAIL frame tag=%0d got=%h expected=%h", mon_e.tag, fw, mon_e.word);
                    end
                end
                if (an == 4'b0111) begin got = 4'b0000; fstart = cyc; end
            end
            case (an)
                4'b0111: begin fw[31:24] = seg; got[3] = 1'b1; end
                4'b1011: begin fw[23:16] = seg; got[2] = 1'b1; end
                4'b1101: begin fw[15:8]  = seg; got[1] = 1'b1; end
                4'b1110: begin fw[7:0]   = seg; got[0] = 1'b1; end
                default: ;
            endcase
            prev_an = an;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_an", 32'(an), 32'h7);
        check("reset_seg", 32'(seg), 32'hC0);
        @(negedge clk); btnR = 1'b1;
        step(1);

        step(100);
        expect_display();

        btnS = 1'b1; step(1); btnS = 1'b0; step(30);
        expect_display();

        run_for(100);
        check("model_ten_sec", 32'(t_sec), 32'd10);
        expect_display();
        step(50);
        expect_display();

        adjust(1'b1, 35);
        expect_display();
        adjust(1'b0, 305);
        expect_display();
        blink_check();
        expect_display();

        set_field(1'b0, 59);
        set_field(1'b1, 58);
        expect_display();
        run_for(20 - hz_acc);
        expect_display();
        set_field(1'b1, 58);
        run_for(20 - hz_acc);
        expect_display();

        run_for(30);
        sw[2] = 1'b1; step(6);
        hold_m = 1'b1; held_sec = t_sec;
        run_for(50);
        expect_display();
        sw[2] = 1'b0; step(6);
        hold_m = 1'b0;
        expect_display();

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: run_for(int'($urandom_range(12, 70)));
                1: adjust(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
                2: begin btnS = 1'b1; step(1); btnS = 1'b0; step(20); end
                default: step(int'($urandom_range(1, 30)));
            endcase
            expect_display();
        end

        press();
        step(120);
        @(posedge clk); #3;
        btnR = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'h7);
        check("async_reset_seg", 32'(seg), 32'hC0);
        t_sec = 0; hz_acc = 0; adj_acc = 0; hold_m = 1'b0;
        @(negedge clk); btnR = 1'b1;
        step(1);
        step(40);
        expect_display();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
